// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg: shared PS/2 scan constants, direction and parser-state
// enums, and the scan-code to direction key map used by ps2_dir_sequencer.
package ps2_keys_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;  // extended prefix
    localparam logic [7:0] SC_F0    = 8'hF0;  // break prefix
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    // Direction code doubles as the bit index into the held vector.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } parse_state_t;

    typedef struct packed {
        logic hit;
        dir_t dir;
    } key_map_t;

    // Arrows are only recognised with the E0 prefix; plain 75/72/6B/74 come
    // from the keypad and are ignored. WASD only maps without a prefix.
    function automatic key_map_t map_key(input logic [7:0] code,
                                         input logic       ext,
                                         input logic       accept_wasd);
        key_map_t m;
        m.hit = 1'b0;
        m.dir = DIR_UP;
        if (ext) begin
            case (code)
                SC_UP:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
                SC_DOWN:  begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
                SC_LEFT:  begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
                SC_RIGHT: begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
                default:  ;
            endcase
        end else if (accept_wasd) begin
            case (code)
                SC_W:    begin m.hit = 1'b1; m.dir = DIR_UP;    end
                SC_S:    begin m.hit = 1'b1; m.dir = DIR_DOWN;  end
                SC_A:    begin m.hit = 1'b1; m.dir = DIR_LEFT;  end
                SC_D:    begin m.hit = 1'b1; m.dir = DIR_RIGHT; end
                default: ;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/dir_cmd_fifo.sv
// dir_cmd_fifo: small synchronous FIFO of 2-bit direction commands.
// Ports:
//   clock, reset        system clock, async active-high reset
//   push, data_in       write request and command; accepted when not full,
//                       or when full and a pop happens in the same cycle
//   pop                 read request; ignored while empty
//   data_out            head entry (registered storage, no input path)
//   full, empty, count  occupancy status, count is log2(DEPTH)+1 bits
module dir_cmd_fifo
    import ps2_keys_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  dir_t          data_in,
    input  logic          pop,
    output dir_t          data_out,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    dir_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of statement order.
    // NOTE: the storage array is reset because the head entry drives cmd_dir
    // directly and must read 0 out of reset; at this depth it costs little.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;   // wraps modulo DEPTH
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_dir_sequencer.sv
// ps2_dir_sequencer: turns the raw PS/2 byte stream into direction commands.
// Ports:
//   clock, reset     system clock, async active-high reset
//   key_pressed      one-cycle strobe qualifying key_data
//   key_data         scan byte from the PS/2 interface
//   cmd_ready        consumer takes the head command this cycle
//   ovf_clear        clears the sticky overflow flag (wins over a set)
//   cmd_valid        command FIFO non-empty
//   cmd_dir          head direction (0 up, 1 down, 2 left, 3 right)
//   held             key-down state, bit index = direction code
//   overflow         sticky: a new key-down was dropped on a full FIFO
//   last_code        last decoded key code without prefixes
module ps2_dir_sequencer
    import ps2_keys_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter bit ACCEPT_WASD = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_pressed,
    input  logic [7:0] key_data,
    input  logic       cmd_ready,
    input  logic       ovf_clear,
    output logic       cmd_valid,
    output logic [1:0] cmd_dir,
    output logic [3:0] held,
    output logic       overflow,
    output logic [7:0] last_code
);

    localparam int AW = $clog2(DEPTH);

    parse_state_t  state_q, state_d;
    logic          decode_fire;
    logic          decode_ext;
    logic          decode_brk;
    key_map_t      key;
    logic          make_hit;
    logic          break_hit;
    logic          push_req;
    logic          drop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    dir_t          fifo_head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_d     = state_q;
        decode_fire = 1'b0;
        decode_ext  = 1'b0;
        decode_brk  = 1'b0;
        if (key_pressed) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_data == SC_E0)      state_d = ST_EXT;
                    else if (key_data == SC_F0) state_d = ST_BRK;
                    else                        decode_fire = 1'b1;
                end
                ST_EXT: begin
                    // Repeated E0 keeps the extended prefix pending.
                    if (key_data == SC_F0)      state_d = ST_EXT_BRK;
                    else if (key_data != SC_E0) begin
                        decode_fire = 1'b1;
                        decode_ext  = 1'b1;
                    end
                end
                ST_BRK: begin
                    decode_fire = 1'b1;
                    decode_brk  = 1'b1;
                end
                ST_EXT_BRK: begin
                    decode_fire = 1'b1;
                    decode_ext  = 1'b1;
                    decode_brk  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            if (decode_fire) state_d = ST_IDLE;
        end
    end

    assign key       = map_key(key_data, decode_ext, ACCEPT_WASD);
    assign make_hit  = decode_fire && !decode_brk && key.hit;
    assign break_hit = decode_fire &&  decode_brk && key.hit;
    // Typematic repeats arrive as makes of an already-held key: no new command.
    assign push_req  = make_hit && !held[key.dir];
    // Full only drops the push when no pop frees a slot in the same cycle.
    assign drop      = push_req && fifo_full && !(cmd_ready && !fifo_empty);

    dir_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push_req),
        .data_in  (key.dir),
        .pop      (cmd_ready),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign cmd_valid = (fifo_count != '0);
    assign cmd_dir   = fifo_head;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held      <= '0;
            last_code <= '0;
            overflow  <= 1'b0;
        end else begin
            if (decode_fire) last_code <= key_data;
            if (make_hit)    held[key.dir] <= 1'b1;
            if (break_hit)   held[key.dir] <= 1'b0;
            if (ovf_clear)   overflow <= 1'b0;
            else if (drop)   overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_dir_sequencer.sv
// Directed bench for ps2_dir_sequencer. Two instances share all inputs:
// dut (ACCEPT_WASD=1) and dut_nw (ACCEPT_WASD=0), both DEPTH=4.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_ps2_dir_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_pressed;
    logic [7:0] key_data;
    logic       cmd_ready;
    logic       ovf_clear;

    logic       cmd_valid, nw_cmd_valid;
    logic [1:0] cmd_dir,   nw_cmd_dir;
    logic [3:0] held,      nw_held;
    logic       overflow,  nw_overflow;
    logic [7:0] last_code, nw_last_code;

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    ps2_dir_sequencer #(.DEPTH(4), .ACCEPT_WASD(1'b1)) dut (
        .clock(clock), .reset(reset), .key_pressed(key_pressed),
        .key_data(key_data), .cmd_ready(cmd_ready), .ovf_clear(ovf_clear),
        .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .held(held),
        .overflow(overflow), .last_code(last_code)
    );

    ps2_dir_sequencer #(.DEPTH(4), .ACCEPT_WASD(1'b0)) dut_nw (
        .clock(clock), .reset(reset), .key_pressed(key_pressed),
        .key_data(key_data), .cmd_ready(cmd_ready), .ovf_clear(ovf_clear),
        .cmd_valid(nw_cmd_valid), .cmd_dir(nw_cmd_dir), .held(nw_held),
        .overflow(nw_overflow), .last_code(nw_last_code)
    );

    // One strobed byte; returns on the falling edge after the sampling edge.
    task automatic strobe(input logic [7:0] b, input logic rdy, input logic clr);
        @(negedge clock);
        key_pressed = 1'b1; key_data = b; cmd_ready = rdy; ovf_clear = clr;
        @(negedge clock);
        key_pressed = 1'b0; cmd_ready = 1'b0; ovf_clear = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        strobe(b, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        @(negedge clock); cmd_ready = 1'b1;
        @(negedge clock); cmd_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (cmd_valid !== 1'b0) $display("FAIL rst cmd_valid got %b want 0", cmd_valid); else passed++;
        checks++; if (cmd_dir !== 2'd0) $display("FAIL rst cmd_dir got %0d want 0", cmd_dir); else passed++;
        checks++; if (held !== 4'b0000) $display("FAIL rst held got %b want 0000", held); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL rst overflow got %b want 0", overflow); else passed++;
        checks++; if (last_code !== 8'h00) $display("FAIL rst last_code got %h want 00", last_code); else passed++;
        checks++; if ({nw_cmd_valid, nw_cmd_dir, nw_held, nw_overflow, nw_last_code} !== 16'h0)
            $display("FAIL rst nw_outputs got %h want 0000", {nw_cmd_valid, nw_cmd_dir, nw_held, nw_overflow, nw_last_code});
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_ext_make_stalled();
        do_reset();
        send(8'hE0);
        checks++; if (cmd_valid !== 1'b0) $display("FAIL ext_prefix cmd_valid got %b want 0", cmd_valid); else passed++;
        send(8'h75);
        checks++; if (cmd_valid !== 1'b1) $display("FAIL ext_make cmd_valid got %b want 1", cmd_valid); else passed++;
        checks++; if (cmd_dir !== 2'd0) $display("FAIL ext_make cmd_dir got %0d want 0", cmd_dir); else passed++;
        checks++; if (held !== 4'b0001) $display("FAIL ext_make held got %b want 0001", held); else passed++;
        checks++; if (last_code !== 8'h75) $display("FAIL ext_make last_code got %h want 75", last_code); else passed++;
        send(8'hE0); send(8'hF0); send(8'h75);
        checks++; if (held !== 4'b0000) $display("FAIL ext_break held got %b want 0000", held); else passed++;
        checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd0)
            $display("FAIL ext_break head got v=%b d=%0d want v=1 d=0", cmd_valid, cmd_dir); else passed++;
        pop_one();
        checks++; if (cmd_valid !== 1'b0) $display("FAIL ext_break single_entry cmd_valid got %b want 0", cmd_valid); else passed++;
    endtask

    task automatic test_typematic();
        do_reset();
        for (int i = 0; i < 5; i++) begin send(8'hE0); send(8'h6B); end
        checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd2)
            $display("FAIL typematic head got v=%b d=%0d want v=1 d=2", cmd_valid, cmd_dir); else passed++;
        checks++; if (held !== 4'b0100) $display("FAIL typematic held got %b want 0100", held); else passed++;
        checks++; if (last_code !== 8'h6B) $display("FAIL typematic last_code got %h want 6b", last_code); else passed++;
        pop_one();
        checks++; if (cmd_valid !== 1'b0) $display("FAIL typematic one_cmd cmd_valid got %b want 0", cmd_valid); else passed++;
    endtask

    task automatic test_alias();
        do_reset();
        send(8'h1D);
        checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd0 || held !== 4'b0001)
            $display("FAIL alias_w got v=%b d=%0d h=%b want v=1 d=0 h=0001", cmd_valid, cmd_dir, held); else passed++;
        checks++; if (nw_cmd_valid !== 1'b0 || nw_held !== 4'b0000)
            $display("FAIL nowasd_w got v=%b h=%b want v=0 h=0000", nw_cmd_valid, nw_held); else passed++;
        checks++; if (nw_last_code !== 8'h1D) $display("FAIL nowasd_w last_code got %h want 1d", nw_last_code); else passed++;
        send(8'hE0); send(8'h75);
        checks++; if (held !== 4'b0001) $display("FAIL alias_merge held got %b want 0001", held); else passed++;
        checks++; if (nw_cmd_valid !== 1'b1 || nw_cmd_dir !== 2'd0)
            $display("FAIL nowasd_arrow got v=%b d=%0d want v=1 d=0", nw_cmd_valid, nw_cmd_dir); else passed++;
        pop_one();
        checks++; if (cmd_valid !== 1'b0) $display("FAIL alias_merge one_cmd cmd_valid got %b want 0", cmd_valid); else passed++;
    endtask

    task automatic test_overflow();
        logic [1:0] exp_dir [4];
        exp_dir[0] = 2'd1; exp_dir[1] = 2'd2; exp_dir[2] = 2'd3; exp_dir[3] = 2'd0;
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'h72);
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
        checks++; if (held !== 4'b1111 || overflow !== 1'b0 || cmd_dir !== 2'd0)
            $display("FAIL fill got h=%b o=%b d=%0d want h=1111 o=0 d=0", held, overflow, cmd_dir); else passed++;
        // Drop with a same-cycle clear: clear wins.
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); strobe(8'h75, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0 || held !== 4'b1111)
            $display("FAIL ovf_clear_wins got o=%b h=%b want o=0 h=1111", overflow, held); else passed++;
        // Plain drop: sticky overflow, held still updated.
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h75);
        checks++; if (overflow !== 1'b1 || held !== 4'b1111 || cmd_dir !== 2'd0)
            $display("FAIL ovf_set got o=%b h=%b d=%0d want o=1 h=1111 d=0", overflow, held, cmd_dir); else passed++;
        @(negedge clock); ovf_clear = 1'b1;
        @(negedge clock); ovf_clear = 1'b0;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_clear overflow got %b want 0", overflow); else passed++;
        // Push while full with a same-cycle pop: accepted.
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); strobe(8'h75, 1'b1, 1'b0);
        checks++; if (overflow !== 1'b0 || held !== 4'b1111 || cmd_valid !== 1'b1 || cmd_dir !== 2'd1)
            $display("FAIL push_pop_full got o=%b h=%b v=%b d=%0d want o=0 h=1111 v=1 d=1",
                     overflow, held, cmd_valid, cmd_dir); else passed++;
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (cmd_valid !== 1'b1 || cmd_dir !== exp_dir[i])
                $display("FAIL full_drain[%0d] got v=%b d=%0d want v=1 d=%0d", i, cmd_valid, cmd_dir, exp_dir[i]);
            else passed++;
            @(negedge clock);
        end
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL full_drain empty cmd_valid got %b want 0", cmd_valid); else passed++;
    endtask

    task automatic test_drain_order();
        logic [1:0] exp_dir [3];
        exp_dir[0] = 2'd1; exp_dir[1] = 2'd3; exp_dir[2] = 2'd2;
        do_reset();
        send(8'hE0); send(8'h72); send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B);
        cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (cmd_valid !== 1'b1 || cmd_dir !== exp_dir[i])
                $display("FAIL drain[%0d] got v=%b d=%0d want v=1 d=%0d", i, cmd_valid, cmd_dir, exp_dir[i]);
            else passed++;
            @(negedge clock);
        end
        checks++; if (cmd_valid !== 1'b0) $display("FAIL drain empty cmd_valid got %b want 0", cmd_valid); else passed++;
        @(negedge clock);   // ready while empty has no effect
        cmd_ready = 1'b0;
        checks++; if (cmd_valid !== 1'b0 || held !== 4'b1110)
            $display("FAIL ready_empty got v=%b h=%b want v=0 h=1110", cmd_valid, held); else passed++;
    endtask

    task automatic test_reset_mid_sequence();
        do_reset();
        send(8'h1D); send(8'hE0);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        checks++; if ({cmd_valid, cmd_dir, held, overflow, last_code} !== 16'h0)
            $display("FAIL mid_rst outputs got %h want 0000", {cmd_valid, cmd_dir, held, overflow, last_code}); else passed++;
        reset = 1'b0;
        send(8'h75);
        checks++; if (cmd_valid !== 1'b0 || held !== 4'b0000)
            $display("FAIL mid_rst plain75 got v=%b h=%b want v=0 h=0000", cmd_valid, held); else passed++;
        checks++; if (last_code !== 8'h75) $display("FAIL mid_rst last_code got %h want 75", last_code); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; key_pressed = 1'b0; key_data = 8'h00;
        cmd_ready = 1'b0; ovf_clear = 1'b0;
        test_reset();
        test_ext_make_stalled();
        test_typematic();
        test_alias();
        test_overflow();
        test_drain_order();
        test_reset_mid_sequence();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ps2_dir_sequencer.md
# ps2_dir_sequencer

Sequences the raw PS/2 byte stream from the keyboard controller into clean direction commands for the VGA game logic. Decodes make, break and extended prefixes, and tracks which direction keys are held. Each new key-down becomes one command in a small FIFO, which the VGA side drains through a valid/ready handshake. It sits between the PS/2 interface outputs (byte strobe and data) and the VGA controller's key input.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- ACCEPT_WASD, 1, when 1, W/S/A/D (1D/1B/1C/23) alias up/down/left/right
- clock  input  1  system clock; the only clock
- reset  input  1  asynchronous, active-high
- key_pressed  input  1  one-cycle strobe: key_data holds a new scan byte
- key_data  input  8  scan byte from the PS/2 interface
- cmd_ready  input  1  consumer accepts the head command this cycle
- ovf_clear  input  1  clears the sticky overflow flag
- cmd_valid  output  1  FIFO non-empty; cmd_dir is valid
- cmd_dir  output  2  head direction: 0 up, 1 down, 2 left, 3 right
- held  output  4  current key-down state, bit index = direction code
- overflow  output  1  sticky: a command was dropped because the FIFO was full
- last_code  output  8  last fully decoded key code, without prefixes

## Operation
- Parser FSM advances only on cycles with key_pressed=1. It has four states:
  - IDLE: E0 goes to EXT. F0 goes to BRK. Any other byte is a plain make; decode it, then go to IDLE.
  - EXT: F0 goes to EXT_BRK. E0 stays in EXT. Any other byte is an extended make; decode it, then go to IDLE.
  - BRK: any byte is a plain break; decode it, then go to IDLE.
  - EXT_BRK: any byte is an extended break; decode it, then go to IDLE.
- Key map:
  - Extended codes: 75 up, 72 down, 6B left, 74 right.
  - Plain codes: W/S/A/D only when ACCEPT_WASD=1.
  - Plain 75/72/6B/74 (keypad) are ignored.
  - Unmapped codes are ignored, apart from updating last_code. The FSM still returns to IDLE.
- Make of a mapped key:
  - If its held bit is 0: set the bit and push its direction.
  - If its held bit is already 1 (typematic repeat): no push.
- Break of a mapped key clears its held bit. No push.
- Arrow key and its WASD alias share one held bit.
- last_code updates on every decoded make or break (any key, mapped or not).
- FIFO push while full:
  - The push is dropped, overflow is set, and held is still updated.
  - If a pop happens in the same cycle, the push is accepted and no overflow occurs.
- Pop occurs when cmd_valid && cmd_ready. cmd_ready while empty has no effect.
- overflow: ovf_clear wins over a same-cycle overflow set.
- Reset values:
  - Parser state IDLE; held=0; FIFO empty.
  - cmd_valid=0, cmd_dir=0, overflow=0, last_code=00.
- Reset mid-sequence (e.g. after E0) discards the prefix. The next byte is parsed from IDLE.

## Timing
- Strobe at edge n: FSM state, held and last_code are updated at edge n.
- A push at edge n gives cmd_valid=1 with the new cmd_dir after edge n, so it is visible in cycle n+1. Latency is 1 cycle from strobe to command.
- cmd_dir is stable while cmd_valid && !cmd_ready. The next entry appears the cycle after a pop.
- Sustained throughput is one push and one pop per cycle. Occupancy is unchanged on a simultaneous push and pop.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Pointers are log2(DEPTH) bits wrapping modulo DEPTH. Full and empty are distinguished by a count of log2(DEPTH)+1 bits.

## Structure
- Package ps2_keys_pkg holds:
  - scan constants: E0, F0, 75, 72, 6B, 74, 1D, 1B, 1C, 23;
  - the 2-bit direction enum;
  - the parser state enum.
- Sub-module dir_cmd_fifo (DEPTH, 2-bit data) provides push, pop, full, empty, count.
- The top level contains the parser FSM, key map and held/overflow registers.

## Test plan
- Extended make, consumer stalled: bytes E0,75 with cmd_ready=0 → cmd_valid=1, cmd_dir=0, held=0001. Then E0,F0,75 → held=0000 and the FIFO is unchanged.
- Typematic repeat: E0,6B repeated five times → exactly one command (dir 2), held=0100. last_code=6B.
- Alias merge: 1D then E0,75 with ACCEPT_WASD=1 → one command (dir 0). With ACCEPT_WASD=0, 1D alone → no command and last_code=1D.
- Overflow:
  - DEPTH=4, consumer stalled, makes up, down, left, right, then break up and make up again → 4 entries, overflow=1, 5th command dropped.
  - ovf_clear → overflow=0.
  - Pop in the same cycle as a push while full → push accepted, overflow stays 0.
- Drain order: 3 queued commands (1,3,2) with cmd_ready held high → dirs 1,3,2 appear on consecutive cycles, then cmd_valid=0.
- Reset mid-sequence: E0, then reset, then 75 → parsed as plain 75, no command. All outputs read their reset values during reset.
